// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: opcode encodings used by both the
// fetch stage and the control unit, and the fetch FSM state type.
package cpu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_SLL  = 3'b111;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        WAIT    = 3'd1,
        PRESENT = 3'd2,
        DRAIN   = 3'd3,
        HALT    = 3'd4
    } fetch_state_t;

    function automatic logic is_legal_opcode(input logic [2:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_ADDI, OP_SW, OP_LW, OP_SLL: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps one request outstanding to a variable-latency
// instruction memory, and hands the fetched word downstream through an IF/ID register.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               flush,
    input  logic [PC_W-1:0]    flush_pc,
    output logic               halted,
    output logic [PC_W-1:0]    illegal_pc
);

    fetch_state_t       state, stateNext;
    logic [PC_W-1:0]    pc, pcNext;
    logic [PC_W-1:0]    reqAddr, reqAddrNext;
    logic [INSTR_W-1:0] instrQ, instrNext;
    logic [PC_W-1:0]    instrPcQ, instrPcNext;
    logic               instrValidQ, instrValidNext;
    logic               haltedQ, haltedNext;
    logic [PC_W-1:0]    illegalPcQ, illegalPcNext;
    logic               reqActive;
    logic [2:0]         opcode;

    assign opcode = imem_rdata[INSTR_W-1 -: 3];

    // NOTE: every sequential state element uses non-blocking assignments so all
    // registers update together from the values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= stateNext;
    end

    // NOTE: each signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        reqAddrNext    = reqAddr;
        instrNext      = instrQ;
        instrPcNext    = instrPcQ;
        instrValidNext = instrValidQ;
        haltedNext     = haltedQ;
        illegalPcNext  = illegalPcQ;
        reqActive      = 1'b0;

        case (state)
            FETCH: begin
                if (flush) begin
                    pcNext = flush_pc;
                end else begin
                    reqActive   = 1'b1;
                    reqAddrNext = pc;
                    stateNext   = WAIT;
                end
            end

            WAIT: begin
                reqActive = 1'b1;
                if (flush) begin
                    pcNext    = flush_pc;
                    stateNext = imem_valid ? FETCH : DRAIN;
                end else if (imem_valid) begin
                    if (is_legal_opcode(opcode)) begin
                        instrNext      = imem_rdata;
                        instrPcNext    = pc;
                        instrValidNext = 1'b1;
                        pcNext         = pc + PC_W'(1);
                        stateNext      = PRESENT;
                    end else begin
                        illegalPcNext = pc;
                        haltedNext    = 1'b1;
                        stateNext     = HALT;
                    end
                end
            end

            // The old request is still in flight; keep presenting it until its
            // response arrives, then throw the data away.
            DRAIN: begin
                reqActive = 1'b1;
                if (flush)      pcNext    = flush_pc;
                if (imem_valid) stateNext = FETCH;
            end

            PRESENT: begin
                if (flush || instr_ready) begin
                    instrValidNext = 1'b0;
                    stateNext      = FETCH;
                end
            end

            HALT: begin
                if (flush) begin
                    haltedNext = 1'b0;
                    pcNext     = flush_pc;
                    stateNext  = FETCH;
                end
            end

            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            reqAddr     <= RESET_PC;
            instrQ      <= '0;
            instrPcQ    <= '0;
            instrValidQ <= 1'b0;
            haltedQ     <= 1'b0;
            illegalPcQ  <= '0;
        end else begin
            pc          <= pcNext;
            reqAddr     <= reqAddrNext;
            instrQ      <= instrNext;
            instrPcQ    <= instrPcNext;
            instrValidQ <= instrValidNext;
            haltedQ     <= haltedNext;
            illegalPcQ  <= illegalPcNext;
        end
    end

    // While a request is outstanding the address comes from reqAddr, since a
    // flush in WAIT retargets pc before the old response has returned.
    assign imem_req    = reqActive & ~rst;
    assign imem_addr   = (state == FETCH) ? pc : reqAddr;
    assign instr       = instrQ;
    assign instr_pc    = instrPcQ;
    assign instr_valid = instrValidQ;
    assign halted      = haltedQ;
    assign illegal_pc  = illegalPcQ;

    addrStableWhileWaiting: assert property (
        @(posedge clk) disable iff (rst)
        (state inside {WAIT, DRAIN}) && !imem_valid |=> $stable(imem_addr) && imem_req
    );

    instrHeldUntilAccepted: assert property (
        @(posedge clk) disable iff (rst)
        instr_valid && !instr_ready && !flush |=> instr_valid && $stable(instr) && $stable(instr_pc)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural variable-latency instruction memory.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic [7:0] imem_rdata = 8'h00;
    logic       imem_valid = 1'b0;
    logic [7:0] instr;
    logic [7:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       flush;
    logic [7:0] flush_pc;
    logic       halted;
    logic [7:0] illegal_pc;

    instr_fetch #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .halted      (halted),
        .illegal_pc  (illegal_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: latches a request seen mid-cycle, answers memLat cycles later
    // with a one-cycle strobe, and ignores the request still visible in the strobe cycle.
    logic [7:0] mem [256];
    int         memLat  = 1;
    bit         memBusy = 1'b0;
    int         memCnt  = 0;
    logic [7:0] memAddr = 8'h00;
    bit         sReq    = 1'b0;
    logic [7:0] sAddr   = 8'h00;
    bit         lastV;

    always @(negedge clk) begin
        #2;
        sReq  = imem_req;
        sAddr = imem_addr;
    end

    always @(posedge clk) begin
        #1;
        lastV      = imem_valid;
        imem_valid = 1'b0;
        if (memBusy) begin
            if (memCnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem[memAddr];
                memBusy    = 1'b0;
            end else begin
                memCnt--;
            end
        end else if (sReq && !lastV) begin
            if (memLat <= 1) begin
                imem_valid = 1'b1;
                imem_rdata = mem[sAddr];
            end else begin
                memBusy = 1'b1;
                memAddr = sAddr;
                memCnt  = memLat - 2;
            end
        end
    end

    task automatic waitValid(input string tag, input int maxCyc);
        bit ok = 1'b0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk);
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " valid seen"}, 32'(ok), 32'd1);
    endtask

    int  tv [3];
    bit  ok;
    bit  seenV;

    initial begin
        #20000;
        $display("FAIL global timeout");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h20;
        mem[8'h00] = 8'h00;
        mem[8'h01] = 8'h81;
        mem[8'h02] = 8'hA2;
        mem[8'h03] = 8'hC3;
        mem[8'h04] = 8'h25;
        mem[8'h07] = 8'h84;
        mem[8'h10] = 8'h80;
        mem[8'h20] = 8'h86;
        mem[8'hFF] = 8'hE0;

        rst = 1'b1; flush = 1'b0; flush_pc = 8'h00; instr_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outputs", {imem_req, imem_addr, instr, instr_pc, instr_valid, halted, illegal_pc},
              {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;

        // Back-to-back stream with 1-cycle memory and an always-ready consumer.
        for (int k = 0; k < 3; k++) begin
            waitValid("t1", 10);
            tv[k] = cyc;
            check("t1 instr", instr, (k == 0) ? 8'h00 : (k == 1) ? 8'h81 : 8'hA2);
            check("t1 pc", instr_pc, 32'(k));
            @(negedge clk);
            check("t1 one-cycle valid", instr_valid, 1'b0);
        end
        check("t1 period a", tv[1] - tv[0], 32'd3);
        check("t1 period b", tv[2] - tv[1], 32'd3);
        instr_ready = 1'b0;

        // Backpressure: held stable, no new requests.
        waitValid("t2", 10);
        check("t2 instr", {instr, instr_pc}, {8'hC3, 8'h03});
        repeat (5) begin
            @(negedge clk);
            check("t2 hold", {instr, instr_pc, instr_valid, imem_req}, {8'hC3, 8'h03, 1'b1, 1'b0});
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("t2 after accept", {instr_valid, imem_req, imem_addr}, {1'b0, 1'b1, 8'h04});

        // Illegal opcode halts fetch.
        ok = 1'b0; seenV = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid) seenV = 1'b1;
            if (halted) begin
                ok = 1'b1;
                break;
            end
        end
        check("t3 halted", ok, 1'b1);
        check("t3 no valid", seenV, 1'b0);
        check("t3 illegal_pc", illegal_pc, 8'h04);
        repeat (3) begin
            @(negedge clk);
            check("t3 quiet", {imem_req, halted, instr_valid}, {1'b0, 1'b1, 1'b0});
        end
        flush = 1'b1; flush_pc = 8'h10;
        @(negedge clk);
        check("t3 unhalt", {halted, illegal_pc}, {1'b0, 8'h04});
        flush = 1'b0;
        #1;
        check("t3 redirect req", {imem_req, imem_addr}, {1'b1, 8'h10});
        waitValid("t3 redirect", 10);
        check("t3 redirect instr", {instr, instr_pc}, {8'h80, 8'h10});

        // Flush during FETCH to reach addr 7, then flush while waiting (latency 3).
        @(negedge clk);
        flush = 1'b1; flush_pc = 8'h07; memLat = 3;
        #1;
        check("t4 fetch suppressed", imem_req, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("t4 req 7", {imem_req, imem_addr}, {1'b1, 8'h07});
        @(negedge clk);
        flush = 1'b1; flush_pc = 8'h20;
        @(negedge clk);
        flush = 1'b0; memLat = 1;
        check("t4 drain holds", {imem_req, imem_addr}, {1'b1, 8'h07});
        ok = 1'b0; seenV = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid) seenV = 1'b1;
            if (imem_req && imem_addr == 8'h20) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4 req 0x20", ok, 1'b1);
        check("t4 discarded", seenV, 1'b0);
        waitValid("t4", 10);
        check("t4 instr", {instr, instr_pc}, {8'h86, 8'h20});

        // PC wrap from 0xFF.
        @(negedge clk);
        flush = 1'b1; flush_pc = 8'hFF;
        @(negedge clk);
        flush = 1'b0;
        waitValid("t5", 10);
        check("t5 instr", {instr, instr_pc}, {8'hE0, 8'hFF});
        @(negedge clk);
        check("t5 wrap addr", {imem_req, imem_addr}, {1'b1, 8'h00});
        waitValid("t5 wrap", 10);
        check("t5 wrap instr", {instr, instr_pc}, {8'h00, 8'h00});

        // Reset in WAIT with a slow response still in flight.
        @(negedge clk);
        flush = 1'b1; flush_pc = 8'h07; memLat = 3;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6 reset outputs", {imem_req, imem_addr, instr, instr_pc, instr_valid, halted, illegal_pc},
              {1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00});
        memLat = 1;
        @(negedge clk);
        rst = 1'b0;
        waitValid("t6", 10);
        check("t6 first instr", {instr, instr_pc}, {8'h00, 8'h00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
